// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: bundles the byte stream, IV load, encrypt-core and
// output handshake signals of aes_block_loader.
//   slave  - the loader's view (drives in_ready, core_state, out_block, out_valid)
//   master - the environment's view (drives bytes, iv, core_result, out_ready)
interface aes_block_loader_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] iv;
    logic         iv_load;
    logic [127:0] core_state;
    logic [127:0] core_result;
    logic [127:0] out_block;
    logic         out_valid;
    logic         out_ready;
    modport slave (
        input  in_byte, in_valid, iv, iv_load, core_result, out_ready,
        output in_ready, core_state, out_block, out_valid
    );
    modport master (
        output in_byte, in_valid, iv, iv_load, core_result, out_ready,
        input  in_ready, core_state, out_block, out_valid
    );
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles 16 plaintext bytes into an AES state, presents it
// to an external combinational encrypt core, waits CORE_WAIT cycles for the
// core to settle, then registers the ciphertext behind a valid/ready handshake.
//   clk, rst  - clock, synchronous active-high reset
//   bus_io    - aes_block_loader_if.slave: byte stream in, iv/iv_load,
//               core_state out / core_result in, out_block handshake
// Build option: define AES_LOADER_CBC_EN for CBC chaining (core_state is
// assembled XOR chain, chain takes each accepted ciphertext); otherwise ECB.
module aes_block_loader #(
    parameter logic [3:0] CORE_WAIT = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    aes_block_loader_if.slave   bus_io
);
    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_OUT} state_t;
    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   wcnt_q, wcnt_d;
    logic [127:0] asm_q, asm_d;
    logic [127:0] out_q, out_d;
`ifdef AES_LOADER_CBC_EN
    logic [127:0] chain_q, chain_d;
    assign bus_io.core_state = asm_q ^ chain_q;
`else
    logic unused_iv;
    assign unused_iv = ^{bus_io.iv, bus_io.iv_load};
    assign bus_io.core_state = asm_q;
`endif
    assign bus_io.in_ready  = state_q == S_LOAD;
    assign bus_io.out_valid = state_q == S_OUT;
    assign bus_io.out_block = out_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        out_d   = out_q;
`ifdef AES_LOADER_CBC_EN
        chain_d = chain_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (bus_io.in_valid) begin
                    asm_d[{cnt_q, 3'b000} +: 8] = bus_io.in_byte;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = S_WAIT;
                        wcnt_d  = CORE_WAIT;
                    end
                end
`ifdef AES_LOADER_CBC_EN
                // IV only replaces the chain at a block boundary; it may
                // coincide with byte 0 since core_state reads the registered chain.
                if (bus_io.iv_load && cnt_q == 4'd0) chain_d = bus_io.iv;
`endif
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    out_d   = bus_io.core_result;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus_io.out_ready) begin
                    state_d = S_LOAD;
`ifdef AES_LOADER_CBC_EN
                    chain_d = out_q;
`endif
                end
            end
            default: state_d = S_LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q   <= 4'd0;
            wcnt_q  <= 4'd0;
            asm_q   <= '0;
            out_q   <= '0;
`ifdef AES_LOADER_CBC_EN
            chain_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
`ifdef AES_LOADER_CBC_EN
            chain_q <= chain_d;
`endif
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: randomized self-checking bench for aes_block_loader with
// a behavioural AES-128 core and a block-level ECB/CBC reference model.
module tb_aes_block_loader;
`ifdef AES_LOADER_CBC_EN
    localparam bit CBC = 1'b1;
`else
    localparam bit CBC = 1'b0;
`endif
    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] VEC = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [127:0] chain;

    always #5 clk = ~clk;

    aes_block_loader_if if0 ();
    aes_block_loader_if if4 ();

    aes_block_loader #(.CORE_WAIT(4'd1)) u_dut (.clk(clk), .rst(rst), .bus_io(if0));
    aes_block_loader #(.CORE_WAIT(4'd4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(if4));

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= p;
            p = xt(p);
        end
        return r;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] r, p, e;
        r = 8'h01;
        p = x;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gm(r, p);
            p = gm(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] k[16];
        logic [7:0] tmp[4];
        logic [7:0] rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[8*i +: 8];
            s[i] = pt[8*i +: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tmp[0] = sb(k[13]) ^ rc;
            tmp[1] = sb(k[14]);
            tmp[2] = sb(k[15]);
            tmp[3] = sb(k[12]);
            for (int j = 0; j < 4; j++) k[j] ^= tmp[j];
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = xt(rc);
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++)
                    t[rr+4*c] = sb(s[rr+4*((c+rr)%4)]);
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c], 8'd2) ^ gm(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'd2) ^ gm(t[4*c+2], 8'd3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'd2) ^ gm(t[4*c+3], 8'd3);
                    s[4*c+3] = gm(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'd2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    assign if0.core_result = aes_enc(if0.core_state, KEY);
    assign if4.core_result = aes_enc(if4.core_state, KEY);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        if0.in_byte  = b;
        if0.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chain = '0;
    endtask

    // Streams one block (iv_load asserted alongside byte ivpos; 16 = never),
    // then waits for the result and checks latency and ciphertext.
    task automatic send_block(input logic [127:0] pt, input int ivpos, input logic [127:0] ivv,
                              output logic [127:0] exp);
        logic seen;
        int n;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == ivpos) begin
                if0.iv = ivv;
                if0.iv_load = 1'b1;
            end
            push(pt[8*k +: 8]);
            if0.iv_load = 1'b0;
            seen |= if0.out_valid;
            if (k == 0 && ivpos == 0)
                check("iv_byte0", {120'b0, if0.core_state[7:0]},
                      {120'b0, pt[7:0] ^ (CBC ? ivv[7:0] : 8'h00)});
        end
        if (ivpos == 0 && CBC) chain = ivv;
        check("early_valid", {127'b0, seen}, 128'd0);
        check("core_state", if0.core_state, pt ^ chain);
        check("wait_in_ready", {127'b0, if0.in_ready}, 128'd0);
        exp = aes_enc(pt ^ chain, KEY);
        n = 0;
        while (!if0.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 1);
        check("out_block", if0.out_block, exp);
    endtask

    // Holds out_ready low for stall cycles while driving junk, then handshakes.
    task automatic recv(input int stall, input logic [127:0] exp);
        for (int i = 0; i < stall; i++) begin
            if0.in_valid = 1'b1;
            if0.in_byte  = 8'($urandom);
            if0.iv_load  = 1'($urandom);
            if0.iv       = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("stall_valid", {127'b0, if0.out_valid}, 128'd1);
            check("stall_ready", {127'b0, if0.in_ready}, 128'd0);
            check("stall_block", if0.out_block, exp);
        end
        if0.in_valid  = 1'b0;
        if0.iv_load   = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.out_ready = 1'b0;
        check("hs_valid", {127'b0, if0.out_valid}, 128'd0);
        check("hs_ready", {127'b0, if0.in_ready}, 128'd1);
        if (CBC) chain = exp;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp, first, pt, ivv, hold;
        int n, ivpos;
        rst = 1'b1;
        chain = '0;
        if0.in_byte = '0; if0.in_valid = 1'b0; if0.iv = '0; if0.iv_load = 1'b0; if0.out_ready = 1'b0;
        if4.in_byte = '0; if4.in_valid = 1'b0; if4.iv = '0; if4.iv_load = 1'b0; if4.out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {127'b0, if0.in_ready}, 128'd1);
        check("rst_out_valid", {127'b0, if0.out_valid}, 128'd0);
        check("rst_out_block", if0.out_block, '0);
        check("rst_core_state", if0.core_state, '0);

        // Known-answer block, OUT lasts one cycle with out_ready high.
        send_block(PT, 16, '0, first);
        check("vector", if0.out_block, VEC);
        recv(0, first);

        // Same plaintext again: ECB repeats, CBC chains on the first ciphertext.
        send_block(PT, 16, '0, exp);
        check("second_differs", {127'b0, if0.out_block != VEC}, {127'b0, CBC});
        recv(5, exp);

        // Reset after 7 bytes discards the partial block.
        for (int k = 0; k < 7; k++) push(8'($urandom));
        do_reset();
        check("mid_rst_valid", {127'b0, if0.out_valid}, 128'd0);
        check("mid_rst_state", if0.core_state, '0);
        send_block(PT, 16, '0, exp);
        check("post_rst_vector", if0.out_block, VEC);
        recv(2, exp);

        // iv_load mid-block is ignored; with byte 0 it takes effect.
        pt  = {$urandom, $urandom, $urandom, $urandom};
        ivv = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 5, ivv, exp);
        recv(0, exp);
        pt  = {$urandom, $urandom, $urandom, $urandom};
        ivv = {$urandom, $urandom, $urandom, $urandom};
        send_block(pt, 0, ivv, exp);
        recv(1, exp);

        // Reset while a result is pending drops it.
        send_block(PT ^ 128'h1, 16, '0, exp);
        do_reset();
        check("out_rst_valid", {127'b0, if0.out_valid}, 128'd0);
        check("out_rst_block", if0.out_block, '0);

        for (int b = 0; b < 6; b++) begin
            pt    = {$urandom, $urandom, $urandom, $urandom};
            ivv   = {$urandom, $urandom, $urandom, $urandom};
            ivpos = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 16));
            send_block(pt, ivpos, ivv, exp);
            recv(int'($urandom_range(0, 5)), exp);
        end

        // CORE_WAIT=4 instance: latency and core_state stability while waiting.
        pt = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 16; k++) begin
            if4.in_byte  = pt[8*k +: 8];
            if4.in_valid = 1'b1;
            @(posedge clk);
            #1;
            if4.in_valid = 1'b0;
        end
        n = 0;
        hold = if4.core_state;
        check("w4_core_state", hold, pt);
        while (!if4.out_valid && n < 20) begin
            check("w4_stable", if4.core_state, pt);
            @(posedge clk);
            #1;
            n++;
        end
        check("w4_latency", n, 4);
        check("w4_block", if4.out_block, aes_enc(pt, KEY));
        if4.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.out_ready = 1'b0;
        check("w4_hs_valid", {127'b0, if4.out_valid}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
